// File: rtl/axi_pkg.sv
// Shared AXI definitions for the instruction- and data-side SRAM-to-AXI bridges.
// Holds the bridge FSM state encoding and the fixed AXI attribute codes.
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } bridge_state_t;

  localparam logic [1:0] AXI_BURST_INCR     = 2'b01;
  localparam logic [3:0] AXI_CACHE_UNCACHED = 4'b0000;
  localparam logic [3:0] AXI_CACHE_WB       = 4'b1111;

endpackage

// File: rtl/inst_axi_bridge.sv
// Read-only bridge from the instruction-fetch SRAM-like port to an AXI4 read master.
// One fetch outstanding at a time: single-beat AR, and the last R beat is returned as inst_data_ok.
module inst_axi_bridge
  import axi_pkg::*;
#(
  parameter int          ID_WIDTH = 4,
  parameter int unsigned ARID     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [31:0]         inst_addr,
  input  logic [31:0]         inst_wdata,
  input  logic                inst_uncached,
  output logic [31:0]         inst_rdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_WIDTH-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);

  bridge_state_t r_state;
  logic [31:0]   r_addr;
  logic [1:0]    r_size;
  logic          r_unc;

  logic          w_last_beat;
  logic          w_unused;

  // Writes, write data, read IDs and responses have no effect on this read-only path.
  assign w_unused = ^{inst_wr, inst_wdata, rid, rresp};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_size  <= '0;
      r_unc   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (inst_req) begin
            r_addr  <= inst_addr;
            r_size  <= inst_size;
            r_unc   <= inst_uncached;
            r_state <= AR;
          end
        end
        AR: begin
          if (arready) r_state <= R;
        end
        R: begin
          if (rvalid && rlast) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Beats without rlast are drained silently; only the final beat reaches the fetch stage.
  assign w_last_beat  = (r_state == R) && rvalid && rlast;

  assign inst_addr_ok = (r_state == IDLE) && inst_req;
  assign inst_data_ok = w_last_beat;
  assign inst_rdata   = w_last_beat ? rdata : 32'h0;

  assign arvalid = (r_state == AR);
  assign rready  = (r_state == R);

  assign arid    = ID_WIDTH'(ARID);
  assign araddr  = r_addr;
  assign arlen   = 8'h00;
  assign arsize  = {1'b0, r_size};
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = r_unc ? AXI_CACHE_UNCACHED : AXI_CACHE_WB;
  assign arprot  = 3'b000;

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Directed testbench for inst_axi_bridge: hand-computed expectations per cycle,
// covering reset, zero-wait fetch, AR stall, slow R, stray beats and reset in R.
module tb_inst_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        instReq;
  logic        instWr;
  logic [1:0]  instSize;
  logic [31:0] instAddr;
  logic [31:0] instWdata;
  logic        instUncached;
  logic [31:0] instRdata;
  logic        instAddrOk;
  logic        instDataOk;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int vecCount  = 0;
  int missCount = 0;
  int pulseCount;

  inst_axi_bridge #(.ID_WIDTH(4), .ARID(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (instReq),
    .inst_wr      (instWr),
    .inst_size    (instSize),
    .inst_addr    (instAddr),
    .inst_wdata   (instWdata),
    .inst_uncached(instUncached),
    .inst_rdata   (instRdata),
    .inst_addr_ok (instAddrOk),
    .inst_data_ok (instDataOk),
    .arid         (arid),
    .araddr       (araddr),
    .arlen        (arlen),
    .arsize       (arsize),
    .arburst      (arburst),
    .arlock       (arlock),
    .arcache      (arcache),
    .arprot       (arprot),
    .arvalid      (arvalid),
    .arready      (arready),
    .rid          (rid),
    .rdata        (rdata),
    .rresp        (rresp),
    .rlast        (rlast),
    .rvalid       (rvalid),
    .rready       (rready)
  );

  always #5 clk = ~clk;

  // Compares one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives all fetch-side and AXI-side inputs for the current cycle, then lets outputs settle.
  task automatic applyStimulus(input logic req, input logic wr, input logic [1:0] size,
                               input logic [31:0] addr, input logic unc, input logic arRdy,
                               input logic rVld, input logic rLst, input logic [31:0] rDat);
    instReq      = req;
    instWr       = wr;
    instSize     = size;
    instAddr     = addr;
    instUncached = unc;
    arready      = arRdy;
    rvalid       = rVld;
    rlast        = rLst;
    rdata        = rDat;
    #1;
  endtask

  // Advances to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    instWdata = 32'hFFFF_FFFF;
    rid       = 4'hF;
    rresp     = 2'b10;
    applyStimulus(0, 0, 2'b10, 32'h0, 0, 0, 0, 0, 32'h0);

    // Reset held for three cycles
    repeat (3) nextCycle();
    checkOutput("rst_arvalid", arvalid, 0);
    checkOutput("rst_rready", rready, 0);
    checkOutput("rst_dataok", instDataOk, 0);
    checkOutput("rst_rdata", instRdata, 0);
    checkOutput("rst_addrok", instAddrOk, 0);
    rst = 1'b0;

    // Zero-wait fetch; R data presented early must be ignored until R
    applyStimulus(1, 0, 2'b10, 32'h1FC0_0000, 1, 1, 1, 1, 32'h3C1A_BFC0);
    checkOutput("zw_addrok_c0", instAddrOk, 1);
    checkOutput("zw_arvalid_c0", arvalid, 0);
    checkOutput("zw_rready_c0", rready, 0);
    checkOutput("zw_dataok_c0", instDataOk, 0);
    nextCycle();
    applyStimulus(0, 0, 2'b10, 32'h0, 0, 1, 1, 1, 32'h3C1A_BFC0);
    checkOutput("zw_arvalid_c1", arvalid, 1);
    checkOutput("zw_araddr_c1", araddr, 32'h1FC0_0000);
    checkOutput("zw_arcache_c1", arcache, 4'b0000);
    checkOutput("zw_arsize_c1", arsize, 3'b010);
    checkOutput("zw_arlen_c1", arlen, 0);
    checkOutput("zw_arburst_c1", arburst, 2'b01);
    checkOutput("zw_arid_c1", arid, 0);
    checkOutput("zw_dataok_c1", instDataOk, 0);
    checkOutput("zw_addrok_c1", instAddrOk, 0);
    nextCycle();
    checkOutput("zw_dataok_c2", instDataOk, 1);
    checkOutput("zw_rdata_c2", instRdata, 32'h3C1A_BFC0);
    checkOutput("zw_rready_c2", rready, 1);
    nextCycle();
    applyStimulus(0, 0, 2'b10, 32'h0, 0, 0, 0, 0, 32'h5555_5555);
    checkOutput("zw_dataok_c3", instDataOk, 0);
    checkOutput("zw_rdata_c3", instRdata, 0);
    checkOutput("zw_rready_c3", rready, 0);

    // AR stall: arready low for 5 cycles while a second request is held
    applyStimulus(1, 0, 2'b10, 32'h0000_1000, 0, 0, 0, 0, 32'h0);
    checkOutput("st_addrok_c0", instAddrOk, 1);
    nextCycle();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 2'b10, 32'h0000_2000 + i, 0, 0, 0, 0, 32'h0);
      checkOutput("st_arvalid", arvalid, 1);
      checkOutput("st_araddr", araddr, 32'h0000_1000);
      checkOutput("st_addrok", instAddrOk, 0);
      checkOutput("st_arcache", arcache, 4'b1111);
      nextCycle();
    end
    applyStimulus(1, 0, 2'b10, 32'h0000_2000, 0, 1, 0, 0, 32'h0);
    checkOutput("st_araddr_hs", araddr, 32'h0000_1000);
    nextCycle();

    // Slow R: rvalid arrives 7 cycles after the AR handshake
    pulseCount = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 2'b10, 32'h0000_2000, 0, 0, 0, 0, 32'h0);
      checkOutput("sr_rready", rready, 1);
      checkOutput("sr_addrok", instAddrOk, 0);
      if (instDataOk) pulseCount++;
      nextCycle();
    end
    applyStimulus(1, 0, 2'b10, 32'h0000_3000, 0, 0, 1, 1, 32'hCAFE_F00D);
    checkOutput("sr_rdata", instRdata, 32'hCAFE_F00D);
    checkOutput("sr_addrok_last", instAddrOk, 0);
    if (instDataOk) pulseCount++;
    nextCycle();
    applyStimulus(1, 0, 2'b10, 32'h0000_3000, 0, 0, 0, 0, 32'h0);
    if (instDataOk) pulseCount++;
    checkOutput("sr_pulses", pulseCount, 1);
    checkOutput("sr_next_addrok", instAddrOk, 1);
    nextCycle();

    // Stray beat without rlast is dropped, the rlast beat is delivered
    applyStimulus(0, 0, 2'b10, 32'h0, 0, 1, 0, 0, 32'h0);
    checkOutput("sb_araddr", araddr, 32'h0000_3000);
    nextCycle();
    pulseCount = 0;
    applyStimulus(0, 0, 2'b10, 32'h0, 0, 0, 1, 0, 32'h0000_DEAD);
    checkOutput("sb_dataok_b0", instDataOk, 0);
    checkOutput("sb_rdata_b0", instRdata, 0);
    checkOutput("sb_rready_b0", rready, 1);
    if (instDataOk) pulseCount++;
    nextCycle();
    applyStimulus(0, 0, 2'b10, 32'h0, 0, 0, 1, 1, 32'h0000_1234);
    checkOutput("sb_rdata_b1", instRdata, 32'h0000_1234);
    if (instDataOk) pulseCount++;
    nextCycle();
    applyStimulus(0, 0, 2'b10, 32'h0, 0, 0, 0, 0, 32'h0);
    if (instDataOk) pulseCount++;
    checkOutput("sb_pulses", pulseCount, 1);

    // Reset while waiting for R data
    applyStimulus(1, 0, 2'b10, 32'h0000_4000, 0, 1, 0, 0, 32'h0);
    checkOutput("rr_addrok", instAddrOk, 1);
    nextCycle();
    applyStimulus(0, 0, 2'b10, 32'h0, 0, 1, 0, 0, 32'h0);
    nextCycle();
    checkOutput("rr_rready_pre", rready, 1);
    rst = 1'b1;
    nextCycle();
    checkOutput("rr_rready_post", rready, 0);
    checkOutput("rr_arvalid_post", arvalid, 0);
    rst = 1'b0;
    // Write-flagged, byte-sized request is still issued as a read
    applyStimulus(1, 1, 2'b00, 32'h0000_5000, 1, 0, 0, 0, 32'h0);
    checkOutput("rr_new_addrok", instAddrOk, 1);
    nextCycle();
    applyStimulus(0, 0, 2'b10, 32'h0, 0, 0, 0, 0, 32'h0);
    checkOutput("rr_new_arvalid", arvalid, 1);
    checkOutput("rr_new_araddr", araddr, 32'h0000_5000);
    checkOutput("rr_new_arsize", arsize, 3'b000);
    checkOutput("rr_new_arcache", arcache, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
